// File: rtl/disciplined_divider.sv
// Divides clk down to a 1 Hz pulse and a 0.5 Hz square wave, with a trimmable period and optional realignment to an external trig.
// Latency: one_hz is registered on the cycle cnt reloads 0; a trig edge takes SYNC_STAGES+1 edges to reach one_hz/err_valid.
// Backpressure: none. The block is free-running and its outputs are strobes or levels with no handshake.
module disciplined_divider #(
    parameter int BASE_FREQ   = 32768,
    parameter int TRIM_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 1,
    localparam int CNT_W      = $clog2(BASE_FREQ + 2**(TRIM_W-1))
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trig,
    input  logic                    trig_en,
    input  logic                    trim_load,
    input  logic [TRIM_W-1:0]       trim_val,
    output logic                    one_hz,
    output logic                    half_hz_50,
    output logic signed [CNT_W:0]   phase_err,
    output logic                    err_valid
);

    localparam logic [CNT_W:0]   BASE_L  = (CNT_W+1)'(BASE_FREQ);
    localparam logic [CNT_W-1:0] HOLD_L  = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   EXT_ONE = (CNT_W+1)'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    // vld_q fills with ones after reset so the reset value of the chain is never mistaken for a sampled low
    logic [SYNC_STAGES:0]   vld_q, vld_d;
    logic                   hist_q, hist_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TRIM_W-1:0]      trim_pend_q, trim_pend_d;
    logic [TRIM_W-1:0]      trim_act_q, trim_act_d;
    logic                   one_hz_q, one_hz_d;
    logic                   half_q, half_d;
    logic [CNT_W:0]         phase_q, phase_d;
    logic                   err_valid_q, err_valid_d;

    logic [CNT_W:0]         trim_ext, period, period_m1, half_period, cnt_ext;
    logic                   trig_rise, disc, nat_wrap, load_zero;

    // Period arithmetic and edge detection for the current cycle
    always_comb begin
        trim_ext    = {{(CNT_W+1-TRIM_W){trim_act_q[TRIM_W-1]}}, trim_act_q};
        period      = BASE_L + trim_ext;
        period_m1   = period - EXT_ONE;
        half_period = period >> 1;
        cnt_ext     = {1'b0, cnt_q};
        trig_rise   = sync_q[SYNC_STAGES-1] & ~hist_q & vld_q[SYNC_STAGES];
        disc        = trig_en & trig_rise;
        nat_wrap    = (cnt_ext == period_m1);
        load_zero   = disc | nat_wrap;
    end

    // Next-state: counter, trim staging, pulse/square outputs and phase capture
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], trig};
        vld_d       = {vld_q[SYNC_STAGES-1:0], 1'b1};
        hist_d      = sync_q[SYNC_STAGES-1];
        cnt_d       = load_zero ? '0 : cnt_q + CNT_ONE;
        trim_pend_d = trim_load ? trim_val : trim_pend_q;
        // trim only takes effect at a second boundary so a running second is never stretched or cut
        trim_act_d  = load_zero ? trim_pend_q : trim_act_q;
        // a realign very close to the last wrap would give a runt second, so it is silent
        one_hz_d    = nat_wrap | (disc & (cnt_q > HOLD_L));
        half_d      = half_q ^ one_hz_d;
        phase_d     = phase_q;
        if (disc) begin
            phase_d = (cnt_ext < half_period) ? cnt_ext : (cnt_ext - period);
        end
        err_valid_d = disc;
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            vld_q       <= '0;
            hist_q      <= 1'b0;
            cnt_q       <= '0;
            trim_pend_q <= '0;
            trim_act_q  <= '0;
            one_hz_q    <= 1'b0;
            half_q      <= 1'b0;
            phase_q     <= '0;
            err_valid_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            vld_q       <= vld_d;
            hist_q      <= hist_d;
            cnt_q       <= cnt_d;
            trim_pend_q <= trim_pend_d;
            trim_act_q  <= trim_act_d;
            one_hz_q    <= one_hz_d;
            half_q      <= half_d;
            phase_q     <= phase_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign one_hz     = one_hz_q;
    assign half_hz_50 = half_q;
    assign phase_err  = phase_q;
    assign err_valid  = err_valid_q;

endmodule
